// File: rtl/cp0_excp_unit_pkg.sv
// cp0_excp_unit_pkg
// Shared CP0/exception definitions: pipeline exception vector layout,
// asynchronous interrupt line layout, CP0 register addresses, ExcCode
// values and packed views of the Status and Cause registers.
package cp0_excp_unit_pkg;

  // Per-instruction exception vector carried down the pipeline (MSB first).
  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Overflow;
    logic Syscall;
    logic Break;
    logic Eret;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
  } ExceptinPipeType;

  // Position of Eret inside ExceptinPipeType; Eret alone is not a trap.
  localparam logic [8:0] PIPE_ERET_MASK = 9'b0_0000_0100;

  // Hardware interrupt lines, bit5 = HardwareInterrupt1.
  typedef struct packed {
    logic HardwareInterrupt1;
    logic HardwareInterrupt2;
    logic HardwareInterrupt3;
    logic HardwareInterrupt4;
    logic HardwareInterrupt5;
    logic HardwareInterrupt6;
  } AsynExceptType;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC_ADDR = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_ALU
  } badvaddr_sel_e;

  typedef struct packed {
    logic [8:0] rsv_31_23;
    logic       bev;
    logic [5:0] rsv_21_16;
    logic [7:0] im;
    logic [5:0] rsv_7_2;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsv_29_16;
    logic [7:0]  ip;
    logic        rsv_7;
    logic [4:0]  exc_code;
    logic [1:0]  rsv_1_0;
  } cp0_cause_t;

endpackage

// File: rtl/cp0_excp_unit_prio.sv
// cp0_excp_prio
// Combinational trap arbiter.
//   except_vec   : exception vector of the MEM instruction (already gated by valid)
//   int_pending  : unmasked interrupt pending (already gated by valid)
//   taken        : a trap is taken
//   is_eret      : eret with nothing else to report
//   exc_code     : ExcCode of the highest-priority cause
//   badvaddr_sel : which address, if any, loads BadVAddr
module cp0_excp_prio
  import cp0_excp_unit_pkg::*;
(
  input  ExceptinPipeType except_vec,
  input  logic            int_pending,
  output logic            taken,
  output logic            is_eret,
  output logic [4:0]      exc_code,
  output badvaddr_sel_e   badvaddr_sel
);

  logic [8:0] vec_bits;
  assign vec_bits = except_vec;

  always_comb begin
    taken        = int_pending | (|(vec_bits & ~PIPE_ERET_MASK));
    is_eret      = ~taken & except_vec.Eret;
    exc_code     = EXC_INT;
    badvaddr_sel = BADV_NONE;
    if (int_pending || except_vec.Interrupt) begin
      exc_code = EXC_INT;
    end else if (except_vec.WrongAddressinIF) begin
      exc_code     = EXC_ADEL;
      badvaddr_sel = BADV_PC;
    end else if (except_vec.ReservedInstruction) begin
      exc_code = EXC_RI;
    end else if (except_vec.Overflow) begin
      exc_code = EXC_OV;
    end else if (except_vec.Syscall) begin
      exc_code = EXC_SYS;
    end else if (except_vec.Break) begin
      exc_code = EXC_BP;
    end else if (except_vec.RdWrongAddressinMEM) begin
      exc_code     = EXC_ADEL;
      badvaddr_sel = BADV_ALU;
    end else if (except_vec.WrWrongAddressinMEM) begin
      exc_code     = EXC_ADES;
      badvaddr_sel = BADV_ALU;
    end
  end

endmodule

// File: rtl/cp0_excp_unit.sv
// cp0_excp_unit
// CP0 register file and exception commit point at MEM.
//   MEM_*       : MEM-stage instruction, its exception vector, PC and data address
//   Ext_Int     : hardware interrupt lines
//   WB_CP0*     : MTC0 write committing from WB
//   CP0_RdAddr / CP0_RdData : MFC0 read port (WB-bypassed)
//   Exc_Flush / Exc_NPC     : pipeline flush and redirect target
//   Int_Pending, CP0_EPC, CP0_Status : status outputs
module cp0_excp_unit
  import cp0_excp_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Valid,
  input  logic [8:0]  MEM_ExceptType,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_IsDelaySlot,
  input  logic [31:0] MEM_ALUOut,
  input  logic [5:0]  Ext_Int,
  input  logic        WB_CP0Wr,
  input  logic [4:0]  WB_CP0Addr,
  input  logic [2:0]  WB_CP0Sel,
  input  logic [31:0] WB_CP0Data,
  input  logic [4:0]  CP0_RdAddr,
  output logic [31:0] CP0_RdData,
  output logic        Exc_Flush,
  output logic [31:0] Exc_NPC,
  output logic        Int_Pending,
  output logic [31:0] CP0_EPC,
  output logic [31:0] CP0_Status
);

  cp0_status_t status_q, status_n;
  cp0_cause_t  cause_q, cause_n;
  logic [31:0] epc_q, epc_n, badvaddr_q, badvaddr_n;
  logic [31:0] count_q, count_n, compare_q, compare_n;
  logic        tick_q;

  logic wb_wr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic int_raw;
  logic prio_taken, prio_eret, trap, eret;
  logic [4:0] prio_code;
  badvaddr_sel_e prio_badv;
  ExceptinPipeType mem_vec;
  logic [31:0] rd_reg;
  logic        rd_impl;

  assign wb_wr      = WB_CP0Wr & (WB_CP0Sel == 3'd0);
  assign wr_count   = wb_wr & (WB_CP0Addr == CP0_COUNT);
  assign wr_compare = wb_wr & (WB_CP0Addr == CP0_COMPARE);
  assign wr_status  = wb_wr & (WB_CP0Addr == CP0_STATUS);
  assign wr_cause   = wb_wr & (WB_CP0Addr == CP0_CAUSE);
  assign wr_epc     = wb_wr & (WB_CP0Addr == CP0_EPC_ADDR);

  assign int_raw     = status_q.ie & ~status_q.exl & (|(cause_q.ip & status_q.im));
  assign Int_Pending = ~rst & int_raw;

  assign mem_vec = MEM_Valid ? ExceptinPipeType'(MEM_ExceptType) : '0;

  cp0_excp_prio u_prio (
    .except_vec  (mem_vec),
    .int_pending (MEM_Valid & int_raw),
    .taken       (prio_taken),
    .is_eret     (prio_eret),
    .exc_code    (prio_code),
    .badvaddr_sel(prio_badv)
  );

  assign trap       = ~rst & prio_taken;
  assign eret       = ~rst & prio_eret;
  assign CP0_EPC    = wr_epc ? WB_CP0Data : epc_q;
  assign CP0_Status = status_q;
  assign Exc_Flush  = trap | eret;
  assign Exc_NPC    = eret ? CP0_EPC : EXC_VECTOR;

  // MTC0 effects are applied first; trap/eret fields then take precedence.
  always_comb begin
    status_n   = status_q;
    cause_n    = cause_q;
    epc_n      = wr_epc ? WB_CP0Data : epc_q;
    badvaddr_n = badvaddr_q;
    compare_n  = wr_compare ? WB_CP0Data : compare_q;
    count_n    = wr_count ? WB_CP0Data : count_q + {31'b0, tick_q};
    if (wr_status) begin
      status_n.im  = WB_CP0Data[15:8];
      status_n.exl = WB_CP0Data[1];
      status_n.ie  = WB_CP0Data[0];
    end
    if (wr_cause) cause_n.ip[1:0] = WB_CP0Data[9:8];
    if (wr_compare)                cause_n.ti = 1'b0;
    else if (count_n == compare_n) cause_n.ti = 1'b1;
    cause_n.ip[7:2] = {cause_n.ti | Ext_Int[5], Ext_Int[4:0]};
    if (trap) begin
      cause_n.exc_code = prio_code;
      status_n.exl     = 1'b1;
      if (!status_q.exl) begin
        epc_n      = MEM_IsDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
        cause_n.bd = MEM_IsDelaySlot;
      end
      if (prio_badv == BADV_PC)       badvaddr_n = MEM_PC;
      else if (prio_badv == BADV_ALU) badvaddr_n = MEM_ALUOut;
    end else if (eret) begin
      status_n.exl = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      status_q   <= status_n;
      cause_q    <= cause_n;
      epc_q      <= epc_n;
      badvaddr_q <= badvaddr_n;
      count_q    <= count_n;
      compare_q  <= compare_n;
      tick_q     <= ~tick_q;
    end
  end

  always_comb begin
    rd_impl = 1'b1;
    rd_reg  = '0;
    case (CP0_RdAddr)
      CP0_BADVADDR: rd_reg = badvaddr_q;
      CP0_COUNT:    rd_reg = count_q;
      CP0_COMPARE:  rd_reg = compare_q;
      CP0_STATUS:   rd_reg = status_q;
      CP0_CAUSE:    rd_reg = cause_q;
      CP0_EPC_ADDR: rd_reg = epc_q;
      default:      rd_impl = 1'b0;
    endcase
    if (rst)
      CP0_RdData = '0;
    else if (rd_impl && wb_wr && (WB_CP0Addr == CP0_RdAddr))
      CP0_RdData = WB_CP0Data;
    else
      CP0_RdData = rd_reg;
  end

endmodule
